// File: rtl/adc_spi_sched.sv
// Per-channel command FIFOs feeding two AD7768 config SPI engines over a shared
// write-data bus, with round-robin issue and one readback strobe per transfer.
module adc_spi_sched #(
    parameter int DEPTH       = 8,
    parameter int XFER_CLOCKS = 64,
    parameter int GAP         = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_chan,
    input  logic [15:0] req_data,
    output logic        req_ready,
    output logic [1:0]  spi_wvalid,
    output logic [15:0] spi_wdata,
    input  logic [7:0]  spi_rdata0,
    input  logic [7:0]  spi_rdata1,
    output logic        resp_valid,
    output logic        resp_chan,
    output logic [7:0]  resp_data,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(XFER_CLOCKS + GAP + 1);
    localparam logic [CW-1:0] LOAD   = CW'(XFER_CLOCKS + GAP);
    localparam logic [CW-1:0] SAMPLE = CW'(GAP + 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);

    logic [15:0]   mem    [2][DEPTH];
    logic [AW-1:0] wr_ptr [2];
    logic [AW-1:0] rd_ptr [2];
    logic [AW:0]   count  [2];
    logic [CW-1:0] cnt    [2];
    logic          last_grant;

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] elig;
    logic [1:0] pop;
    logic       grant_any;
    logic       grant_ch;

    // Handshake: a word transfers on a clock edge where req_valid && req_ready;
    // req_ready depends only on registered FIFO counts and req_chan, never on req_valid.
    assign req_ready = !full[req_chan];

    always_comb begin
        full = '0;
        push = '0;
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            full[i] = (count[i] == FULL);
            push[i] = req_valid && !full[i] && (req_chan == 1'(i));
            // cnt == 1 means the channel is idle by the issuing edge, so back-to-back
            // starts land exactly XFER_CLOCKS+GAP apart.
            elig[i] = (count[i] != '0) && (cnt[i] <= CW'(1));
        end
    end

    always_comb begin
        grant_any = |elig;
        grant_ch  = elig[1];
        if (elig == 2'b11) begin
            grant_ch = !last_grant;
        end
        pop = 2'b00;
        if (grant_any) begin
            pop = grant_ch ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= req_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + (AW + 1)'(1);
                    2'b01:   count[i] <= count[i] - (AW + 1)'(1);
                    default: count[i] <= count[i];
                endcase
                if (pop[i]) begin
                    cnt[i] <= LOAD;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spi_wvalid <= 2'b00;
            spi_wdata  <= '0;
            last_grant <= 1'b1;
            resp_valid <= 1'b0;
            resp_chan  <= 1'b0;
            resp_data  <= '0;
            busy       <= 1'b0;
        end else begin
            spi_wvalid <= pop;
            if (grant_any) begin
                spi_wdata  <= mem[grant_ch][rd_ptr[grant_ch]];
                last_grant <= grant_ch;
            end
            // Issues are at least a cycle apart, so both channels never sample together.
            resp_valid <= (cnt[0] == SAMPLE) || (cnt[1] == SAMPLE);
            if (cnt[0] == SAMPLE) begin
                resp_chan <= 1'b0;
                resp_data <= spi_rdata0;
            end else if (cnt[1] == SAMPLE) begin
                resp_chan <= 1'b1;
                resp_data <= spi_rdata1;
            end
            busy <= (count[0] != '0) || (count[1] != '0) || (cnt[0] != '0) || (cnt[1] != '0);
        end
    end

endmodule

// File: tb/tb_adc_spi_sched.sv
// Directed bench for adc_spi_sched: event monitor on the falling edge, linear
// stimulus with immediate-assertion checks against hand-computed cycle numbers.
module tb_adc_spi_sched;

    localparam int DEPTH = 8;
    localparam int XFER  = 64;
    localparam int GAP   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_chan = 1'b0;
    logic [15:0] req_data = '0;
    logic        req_ready;
    logic [1:0]  spi_wvalid;
    logic [15:0] spi_wdata;
    logic [7:0]  spi_rdata0 = '0;
    logic [7:0]  spi_rdata1 = '0;
    logic        resp_valid;
    logic        resp_chan;
    logic [7:0]  resp_data;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          wv0_t[$];
    int          wv1_t[$];
    logic [15:0] wv0_d[$];
    logic [15:0] wv1_d[$];
    int          rs_t[$];
    logic        rs_c[$];
    logic [7:0]  rs_d[$];
    int          bf_t[$];
    logic        busy_q = 1'b0;
    logic [15:0] exp_q[$];

    adc_spi_sched #(.DEPTH(DEPTH), .XFER_CLOCKS(XFER), .GAP(GAP)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_chan   (req_chan),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .spi_wvalid (spi_wvalid),
        .spi_wdata  (spi_wdata),
        .spi_rdata0 (spi_rdata0),
        .spi_rdata1 (spi_rdata1),
        .resp_valid (resp_valid),
        .resp_chan  (resp_chan),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // event log, sampled away from the active edge
    always @(negedge clock) begin
        if (spi_wvalid[0]) begin
            wv0_t.push_back(cyc);
            wv0_d.push_back(spi_wdata);
        end
        if (spi_wvalid[1]) begin
            wv1_t.push_back(cyc);
            wv1_d.push_back(spi_wdata);
        end
        if (resp_valid) begin
            rs_t.push_back(cyc);
            rs_c.push_back(resp_chan);
            rs_d.push_back(resp_data);
        end
        if (busy_q && !busy) begin
            bf_t.push_back(cyc);
        end
        busy_q <= busy;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    // driver: offer a word and hold it until accepted; acc = acceptance edge
    task automatic push(input logic ch, input logic [15:0] d, output int acc);
        int  n;
        logic rdy;
        n = 0;
        acc = -1;
        req_valid = 1'b1;
        req_chan  = ch;
        req_data  = d;
        #1;
        while (acc < 0 && n < 200) begin
            rdy = req_ready;
            @(posedge clock);
            #1;
            n++;
            if (rdy) acc = cyc;
        end
        req_valid = 1'b0;
        check("push_accepted", (acc >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        tick(2);
        while (busy !== 1'b0 && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        tick(3);
    endtask

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int n;
        n = 0;
        foreach (q[k]) if (q[k] >= lo && q[k] <= hi) n++;
        return n;
    endfunction

    function automatic int idx_from(input int q[$], input int lo);
        foreach (q[k]) if (q[k] >= lo) return k;
        return -1;
    endfunction

    initial begin
        int a, b, c, d, i, j, r;
        int acc[10];

        // reset state
        tick(3);
        check("rst_wvalid", 32'(spi_wvalid), 32'd0);
        check("rst_wdata", 32'(spi_wdata), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_chan", 32'(resp_chan), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        tick(2);

        // single word, full latency profile
        spi_rdata0 = 8'hA5;
        push(1'b0, 16'h8155, a);
        wait_idle("t1_idle");
        i = idx_from(wv0_t, a);
        check("t1_issue_cyc", (i >= 0) ? wv0_t[i] - a : -1, 32'd1);
        check("t1_wdata", (i >= 0) ? 32'(wv0_d[i]) : 32'hffffffff, 32'h8155);
        check("t1_wv0_count", count_in(wv0_t, a, cyc), 32'd1);
        check("t1_wv1_count", count_in(wv1_t, a, cyc), 32'd0);
        j = idx_from(rs_t, a);
        check("t1_resp_cyc", (j >= 0) ? rs_t[j] - a : -1, 32'd65);
        check("t1_resp_chan", (j >= 0) ? 32'(rs_c[j]) : 32'hffffffff, 32'd0);
        check("t1_resp_data", (j >= 0) ? 32'(rs_d[j]) : 32'hffffffff, 32'hA5);
        check("t1_resp_count", count_in(rs_t, a, cyc), 32'd1);
        i = idx_from(bf_t, a);
        check("t1_busy_fall", (i >= 0) ? bf_t[i] - a : -1, 32'd70);

        // two channels in one burst
        spi_rdata0 = 8'h11;
        spi_rdata1 = 8'h22;
        push(1'b0, 16'h0101, a);
        push(1'b1, 16'h0202, b);
        wait_idle("t2_idle");
        check("t2_push_gap", b - a, 32'd1);
        i = idx_from(wv0_t, a);
        check("t2_ch0_cyc", (i >= 0) ? wv0_t[i] - a : -1, 32'd1);
        check("t2_ch0_data", (i >= 0) ? 32'(wv0_d[i]) : 32'hffffffff, 32'h0101);
        i = idx_from(wv1_t, a);
        check("t2_ch1_cyc", (i >= 0) ? wv1_t[i] - a : -1, 32'd2);
        check("t2_ch1_data", (i >= 0) ? 32'(wv1_d[i]) : 32'hffffffff, 32'h0202);
        j = idx_from(rs_t, a);
        check("t2_resp_count", count_in(rs_t, a, cyc), 32'd2);
        check("t2_resp0_cyc", (j >= 0) ? rs_t[j] - a : -1, 32'd65);
        check("t2_resp0_chan", (j >= 0) ? 32'(rs_c[j]) : 32'hffffffff, 32'd0);
        check("t2_resp0_data", (j >= 0) ? 32'(rs_d[j]) : 32'hffffffff, 32'h11);
        check("t2_resp1_cyc", (j >= 0 && j + 1 < rs_t.size()) ? rs_t[j+1] - a : -1, 32'd66);
        check("t2_resp1_chan", (j >= 0 && j + 1 < rs_c.size()) ? 32'(rs_c[j+1]) : 32'hffffffff, 32'd1);
        check("t2_resp1_data", (j >= 0 && j + 1 < rs_d.size()) ? 32'(rs_d[j+1]) : 32'hffffffff, 32'h22);

        // back-to-back words on ch1
        spi_rdata1 = 8'h3C;
        push(1'b1, 16'h1111, a);
        push(1'b1, 16'h2222, b);
        push(1'b1, 16'h3333, c);
        wait_idle("t3_idle");
        i = idx_from(wv1_t, a);
        check("t3_count", count_in(wv1_t, a, cyc), 32'd3);
        check("t3_ch0_quiet", count_in(wv0_t, a, cyc), 32'd0);
        check("t3_start0", (i >= 0) ? wv1_t[i] - a : -1, 32'd1);
        check("t3_spacing1", (i >= 0 && i + 1 < wv1_t.size()) ? wv1_t[i+1] - wv1_t[i] : -1, 32'd68);
        check("t3_spacing2", (i >= 0 && i + 2 < wv1_t.size()) ? wv1_t[i+2] - wv1_t[i+1] : -1, 32'd68);
        check("t3_data0", (i >= 0) ? 32'(wv1_d[i]) : 32'hffffffff, 32'h1111);
        check("t3_data1", (i >= 0 && i + 1 < wv1_d.size()) ? 32'(wv1_d[i+1]) : 32'hffffffff, 32'h2222);
        check("t3_data2", (i >= 0 && i + 2 < wv1_d.size()) ? 32'(wv1_d[i+2]) : 32'hffffffff, 32'h3333);

        // fill ch0 past DEPTH while its engine is busy
        for (int k = 0; k < DEPTH + 1; k++) begin
            push(1'b0, 16'h4000 + 16'(k), acc[k]);
            exp_q.push_back(16'h4000 + 16'(k));
        end
        check("t4_accept_run", acc[DEPTH] - acc[0], 32'(DEPTH));
        req_valid = 1'b1;
        req_chan  = 1'b0;
        req_data  = 16'h4009;
        #1;
        check("t4_ready0_full", 32'(req_ready), 32'd0);
        req_chan = 1'b1;
        #1;
        check("t4_ready1", 32'(req_ready), 32'd1);
        req_chan = 1'b0;
        push(1'b0, 16'h4009, acc[9]);
        exp_q.push_back(16'h4009);
        check("t4_refused_accept", acc[9] - acc[0], 32'd70);
        wait_idle("t4_idle");
        check("t4_issue_count", count_in(wv0_t, acc[0], cyc), 32'd10);
        i = idx_from(wv0_t, acc[0]);
        for (int k = 0; k < 10; k++) begin
            check("t4_order", (i >= 0 && i + k < wv0_d.size()) ? 32'(wv0_d[i+k]) : 32'hffffffff,
                  32'(exp_q.pop_front()));
        end

        // tie with ch1 granted last: ch0 wins
        push(1'b1, 16'h5001, a);
        push(1'b1, 16'h5002, b);
        wait_until(a + 67);
        push(1'b0, 16'h5003, c);
        check("t5a_push_cyc", c - a, 32'd68);
        wait_idle("t5a_idle");
        i = idx_from(wv0_t, a);
        check("t5a_ch0_cyc", (i >= 0) ? wv0_t[i] - a : -1, 32'd69);
        i = idx_from(wv1_t, a + 2);
        check("t5a_ch1_cyc", (i >= 0) ? wv1_t[i] - a : -1, 32'd70);

        // tie with ch0 granted last: ch1 wins
        push(1'b0, 16'h6001, a);
        push(1'b0, 16'h6002, b);
        wait_until(a + 67);
        push(1'b1, 16'h6003, c);
        check("t5b_push_cyc", c - a, 32'd68);
        wait_idle("t5b_idle");
        i = idx_from(wv1_t, a);
        check("t5b_ch1_cyc", (i >= 0) ? wv1_t[i] - a : -1, 32'd69);
        i = idx_from(wv0_t, a + 2);
        check("t5b_ch0_cyc", (i >= 0) ? wv0_t[i] - a : -1, 32'd70);

        // reset 20 clocks into a ch0 transfer with two words queued
        push(1'b0, 16'h7001, a);
        push(1'b0, 16'h7002, b);
        push(1'b0, 16'h7003, c);
        wait_until(a + 21);
        #3;
        reset = 1'b1;
        #1;
        check("t6_wvalid", 32'(spi_wvalid), 32'd0);
        check("t6_wdata", 32'(spi_wdata), 32'd0);
        check("t6_resp_valid", 32'(resp_valid), 32'd0);
        check("t6_resp_data", 32'(resp_data), 32'd0);
        check("t6_resp_chan", 32'(resp_chan), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b0;
        r = cyc;
        tick(100);
        check("t6_no_resp", count_in(rs_t, a, cyc), 32'd0);
        check("t6_no_issue", count_in(wv0_t, a + 2, cyc), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_ready", 32'(req_ready), 32'd1);
        push(1'b0, 16'h7777, d);
        wait_idle("t6_idle2");
        i = idx_from(wv0_t, d);
        check("t6_new_cyc", (i >= 0) ? wv0_t[i] - d : -1, 32'd1);
        check("t6_new_data", (i >= 0) ? 32'(wv0_d[i]) : 32'hffffffff, 32'h7777);
        j = idx_from(rs_t, d);
        check("t6_new_resp", (j >= 0) ? rs_t[j] - d : -1, 32'd65);
        check("t6_resp_after", count_in(rs_t, r, cyc), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
